// File: rtl/pipe_pkg.sv
// Shared definitions for the handshaked pipeline stage register.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } pipe_state_e;

    // Bubble control word; wide enough for any CTRL_W, sliced at use.
    localparam logic [255:0] CTRL_NOP = '0;

endpackage

// File: rtl/pipe_slot.sv
// One pipeline entry: data + control payload with load enable and a
// control-only clear used to turn the entry into a bubble.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int DATA_W = 128,
    parameter int CTRL_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              clr_ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    output logic [DATA_W-1:0] data_o,
    output logic [CTRL_W-1:0] ctrl_o
);

    // Data is only ever loaded; control is cleared ahead of a load.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            data_o <= '0;
            ctrl_o <= '0;
        end else begin
            if (load_i) begin
                data_o <= data_i;
            end
            if (clr_ctrl_i) begin
                ctrl_o <= CTRL_NOP[CTRL_W-1:0];
            end else if (load_i) begin
                ctrl_o <= ctrl_i;
            end
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Reusable valid/ready pipeline stage with optional 2-entry skid buffer,
// flush-to-bubble and a saturating stall counter.
//
//   state    | meaning
//   ST_EMPTY | no entry held, valid_o=0
//   ST_FULL  | main slot holds the head beat
//   ST_SKID  | main + skid slots both hold beats, input blocked
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W  = 128,
    parameter int CTRL_W  = 16,
    parameter bit SKID_EN = 1'b1,
    parameter int CNT_W   = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DATA_W-1:0] data_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] data_o,
    output logic [CTRL_W-1:0] ctrl_o,
    input  logic              clr_cnt_i,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    pipe_state_e       state;
    logic              ready_q;
    logic              xfer_in;
    logic              xfer_out;
    logic              main_load;
    logic              skid_load;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data_d;
    logic [CTRL_W-1:0] main_ctrl_d;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;

    assign valid_o  = (state != ST_EMPTY);
    assign ready_o  = SKID_EN ? ready_q : (!valid_o || ready_i);
    assign xfer_in  = valid_i && ready_o;
    assign xfer_out = valid_o && ready_i;
    assign data_o   = main_data;
    assign ctrl_o   = valid_o ? main_ctrl : CTRL_NOP[CTRL_W-1:0];

    // Slot load enables; a flush blocks every load so the incoming beat is dropped.
    always_comb begin
        main_load = 1'b0;
        skid_load = 1'b0;
        if (!flush_i) begin
            case (state)
                ST_EMPTY: main_load = xfer_in;
                ST_FULL: begin
                    main_load = xfer_in && xfer_out;
                    skid_load = SKID_EN && xfer_in && !xfer_out;
                end
                ST_SKID:  main_load = xfer_out;
                default:  main_load = 1'b0;
            endcase
        end
        main_data_d = (state == ST_SKID) ? skid_data : data_i;
        main_ctrl_d = (state == ST_SKID) ? skid_ctrl : ctrl_i;
    end

    pipe_slot #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_main (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (main_load),
        .clr_ctrl_i (flush_i),
        .data_i     (main_data_d),
        .ctrl_i     (main_ctrl_d),
        .data_o     (main_data),
        .ctrl_o     (main_ctrl)
    );

    if (SKID_EN) begin : g_skid
        pipe_slot #(
            .DATA_W (DATA_W),
            .CTRL_W (CTRL_W)
        ) u_skid (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .load_i     (skid_load),
            .clr_ctrl_i (flush_i),
            .data_i     (data_i),
            .ctrl_i     (ctrl_i),
            .data_o     (skid_data),
            .ctrl_o     (skid_ctrl)
        );
    end else begin : g_no_skid
        assign skid_data = '0;
        assign skid_ctrl = '0;
    end

    // Occupancy FSM; ready_q is registered so it drops the cycle after the skid fills.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state   <= ST_EMPTY;
            ready_q <= 1'b1;
        end else if (flush_i) begin
            state   <= ST_EMPTY;
            ready_q <= 1'b1;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (xfer_in) begin
                        state <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (xfer_in && !xfer_out) begin
                        if (SKID_EN) begin
                            state   <= ST_SKID;
                            ready_q <= 1'b0;
                        end
                    end else if (!xfer_in && xfer_out) begin
                        state <= ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (xfer_out) begin
                        state   <= ST_FULL;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state   <= ST_EMPTY;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Saturating count of cycles where the head beat is held back downstream.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_o <= '0;
        end else if (clr_cnt_i) begin
            stall_cnt_o <= '0;
        end else if (valid_o && !ready_i && (stall_cnt_o != {CNT_W{1'b1}})) begin
            stall_cnt_o <= stall_cnt_o + CNT_W'(1);
        end
    end

endmodule
